// File: rtl/im_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: loader states,
// default PC of word index 0, and header/word geometry.
package im_loader_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } loader_state_e;

    localparam logic [31:0] IM_BASE_PC = 32'h0000_3000;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_W     = 8 * HDR_BYTES;
    localparam int BYTE_CNT_W = $clog2(HDR_BYTES);

endpackage

// File: rtl/im_byte_packer.sv
// Big-endian byte-to-word assembler shared by the header and data phases.
// word_valid_o is combinational and fires on the cycle the 4th byte is accepted.
module im_byte_packer
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    localparam logic [BYTE_CNT_W-1:0] CNT_LAST = BYTE_CNT_W'(HDR_BYTES - 1);
    localparam logic [BYTE_CNT_W-1:0] CNT_ONE  = BYTE_CNT_W'(1);
    localparam int LEAD_W = WORD_W - 8;

    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    // Only the leading bytes of a group need storage; the last one comes straight from byte_i.
    logic [LEAD_W-1:0]     shift_q, shift_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (byte_valid_i) begin
            byte_cnt_d = byte_cnt_q + CNT_ONE;
            shift_d    = {shift_q[LEAD_W-9:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    assign word_valid_o = byte_valid_i && (byte_cnt_q == CNT_LAST);
    assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction memory writer: parses a word-count header, streams
// big-endian words into the memory write port and holds the CPU until done.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int          DEPTH   = 4096,
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] BASE_PC = IM_BASE_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [31:0]       im_pc,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] INDEX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    logic              accept;
    logic              word_valid;
    logic [31:0]       word;
    logic              last_word;

    assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign accept   = in_valid && in_ready;

    im_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (accept),
        .byte_i       (in_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    assign last_word = ({1'b0, index_q} == (word_count_q - COUNT_ONE));

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        im_we_d      = 1'b0;
        im_addr_d    = im_addr_q;
        im_wdata_d   = im_wdata_q;
        done_d       = done_q;
        error_d      = error_q;
        cpu_hold_d   = cpu_hold_q;
        word_count_d = word_count_q;

        case (state_q)
            ST_HDR: begin
                // The oversize test uses the full 32-bit header before it is truncated.
                if (word_valid) begin
                    if (word == 32'd0) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if (word > 32'(DEPTH)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d      = ST_DATA;
                        word_count_d = word[ADDR_W:0];
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = index_q;
                    im_wdata_d = word;
                    // Completion lands together with the final write pulse; the index never wraps.
                    if (last_word) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        index_d = index_q + INDEX_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HDR;
            index_q      <= '0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_hold_q   <= cpu_hold_d;
            word_count_q <= word_count_d;
        end
    end

    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign im_pc      = BASE_PC + {{(30-ADDR_W){1'b0}}, im_addr_q, 2'b00};
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_hold   = cpu_hold_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: scenario tasks plus randomized streams
// compared against a header/word-list model of the load.
module tb_im_loader;

    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [31:0]       im_pc;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;

    typedef logic [7:0]  byteQ_t[$];
    typedef logic [31:0] wordQ_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [31:0]       pc;
        logic              doneF;
        logic              holdF;
        int                cyc;
    } wr_t;

    wr_t  wrQ[$];
    logic accFlag[$];
    int   accEdge[$];

    im_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .im_pc      (im_pc),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Record every memory write with the status flags seen in the same cycle
    always @(negedge clk) begin : monitor
        wr_t w;
        if (im_we === 1'b1) begin
            w.addr  = im_addr;
            w.data  = im_wdata;
            w.pc    = im_pc;
            w.doneF = done;
            w.holdF = cpu_hold;
            w.cyc   = cycleCnt;
            wrQ.push_back(w);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: header, word list and final flags from the byte stream alone
    function automatic void modelLoad(input byteQ_t s, output wordQ_t words, output logic expDone,
                                      output logic expErr, output logic [ADDR_W:0] expCount,
                                      output int expAccepted);
        logic [31:0] n;
        int avail;
        words = {};
        expDone = 1'b0;
        expErr = 1'b0;
        expCount = '0;
        expAccepted = s.size();
        if (s.size() < 4) return;
        n = {s[0], s[1], s[2], s[3]};
        if (n == 32'd0) begin
            expDone = 1'b1;
            expAccepted = 4;
            return;
        end
        if (n > 32'(DEPTH)) begin
            expErr = 1'b1;
            expAccepted = 4;
            return;
        end
        expCount = n[ADDR_W:0];
        avail = (s.size() - 4) / 4;
        for (int i = 0; i < int'(n) && i < avail; i++)
            words.push_back({s[4+4*i], s[5+4*i], s[6+4*i], s[7+4*i]});
        if (avail >= int'(n)) begin
            expDone = 1'b1;
            expAccepted = 4 + 4 * int'(n);
        end
    endfunction

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveByte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        accFlag.push_back(in_ready);
        @(posedge clk);
        #1;
        accEdge.push_back(cycleCnt);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
    endtask

    task automatic applyStimulus(input byteQ_t s, input int gapPct);
        foreach (s[i]) begin
            if (int'($urandom_range(0, 99)) < gapPct) idle(int'($urandom_range(1, 3)));
            driveByte(s[i]);
        end
        idle(3);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        wrQ.delete();
        accFlag.delete();
        accEdge.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_byte = 8'hAA;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset.in_ready: got %b expected 1", in_ready); end
        checks++; if (im_we !== 1'b0) begin errors++; $display("[TB] FAIL reset.im_we: got %b expected 0", im_we); end
        checks++; if (im_addr !== '0) begin errors++; $display("[TB] FAIL reset.im_addr: got %h expected 0", im_addr); end
        checks++; if (im_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset.im_wdata: got %h expected 0", im_wdata); end
        checks++; if (im_pc !== 32'h0000_3000) begin errors++; $display("[TB] FAIL reset.im_pc: got %h expected 00003000", im_pc); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL reset.cpu_hold: got %b expected 1", cpu_hold); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset.done: got %b expected 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset.error: got %b expected 0", error); end
        checks++; if (word_count !== '0) begin errors++; $display("[TB] FAIL reset.word_count: got %0d expected 0", word_count); end
        reset = 1'b0;
        idle(1);
        wrQ.delete();
        accFlag.delete();
        accEdge.delete();
    endtask

    task automatic test_two_words();
        byteQ_t s;
        int nAcc;
        s = {8'h00, 8'h00, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        doReset();
        applyStimulus(s, 0);
        nAcc = 0;
        foreach (accFlag[i]) if (accFlag[i] === 1'b1) nAcc++;
        checks++; if (nAcc !== 12) begin errors++; $display("[TB] FAIL two.accepted: got %0d expected 12", nAcc); end
        checks++; if (wrQ.size() !== 2) begin errors++; $display("[TB] FAIL two.writes: got %0d expected 2", wrQ.size()); end
        if (wrQ.size() >= 2) begin
            checks++; if (wrQ[0].addr !== 12'd0 || wrQ[0].data !== 32'h2408_0005 || wrQ[0].pc !== 32'h0000_3000) begin
                errors++; $display("[TB] FAIL two.w0: got %h/%h/%h expected 000/24080005/00003000", wrQ[0].addr, wrQ[0].data, wrQ[0].pc); end
            checks++; if (wrQ[0].doneF !== 1'b0 || wrQ[0].holdF !== 1'b1) begin
                errors++; $display("[TB] FAIL two.w0flags: got done=%b hold=%b expected done=0 hold=1", wrQ[0].doneF, wrQ[0].holdF); end
            checks++; if (wrQ[1].addr !== 12'd1 || wrQ[1].data !== 32'h0000_000C || wrQ[1].pc !== 32'h0000_3004) begin
                errors++; $display("[TB] FAIL two.w1: got %h/%h/%h expected 001/0000000c/00003004", wrQ[1].addr, wrQ[1].data, wrQ[1].pc); end
            checks++; if (wrQ[1].doneF !== 1'b1 || wrQ[1].holdF !== 1'b0) begin
                errors++; $display("[TB] FAIL two.w1flags: got done=%b hold=%b expected done=1 hold=0", wrQ[1].doneF, wrQ[1].holdF); end
            checks++; if (wrQ[0].cyc !== accEdge[7] || wrQ[1].cyc !== accEdge[11]) begin
                errors++; $display("[TB] FAIL two.latency: got cycles %0d,%0d expected %0d,%0d", wrQ[0].cyc, wrQ[1].cyc, accEdge[7], accEdge[11]); end
        end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || word_count !== 13'd2) begin
            errors++; $display("[TB] FAIL two.final: got done=%b hold=%b ready=%b count=%0d expected 1/0/0/2", done, cpu_hold, in_ready, word_count); end
    endtask

    task automatic test_zero_count();
        byteQ_t s;
        s = {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A};
        doReset();
        applyStimulus(s, 0);
        checks++; if (wrQ.size() !== 0) begin errors++; $display("[TB] FAIL zero.writes: got %0d expected 0", wrQ.size()); end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
            errors++; $display("[TB] FAIL zero.flags: got done=%b hold=%b err=%b expected 1/0/0", done, cpu_hold, error); end
        checks++; if (word_count !== '0) begin errors++; $display("[TB] FAIL zero.count: got %0d expected 0", word_count); end
        checks++; if (in_ready !== 1'b0 || accFlag[4] !== 1'b0 || accFlag[5] !== 1'b0) begin
            errors++; $display("[TB] FAIL zero.refuse: got ready=%b acc4=%b acc5=%b expected 0/0/0", in_ready, accFlag[4], accFlag[5]); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 2; k++) begin
            byteQ_t s;
            int nAcc;
            if (k == 0) s = {8'h00, 8'h00, 8'h10, 8'h01};
            else        s = {8'h00, 8'h01, 8'h00, 8'h01};
            for (int j = 0; j < 8; j++) s.push_back(8'($urandom));
            doReset();
            applyStimulus(s, 20);
            nAcc = 0;
            foreach (accFlag[i]) if (accFlag[i] === 1'b1) nAcc++;
            checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
                errors++; $display("[TB] FAIL overflow%0d.flags: got err=%b hold=%b ready=%b done=%b expected 1/1/0/0", k, error, cpu_hold, in_ready, done); end
            checks++; if (wrQ.size() !== 0) begin errors++; $display("[TB] FAIL overflow%0d.writes: got %0d expected 0", k, wrQ.size()); end
            checks++; if (nAcc !== 4 || word_count !== '0) begin
                errors++; $display("[TB] FAIL overflow%0d.accept: got acc=%0d count=%0d expected 4/0", k, nAcc, word_count); end
        end
    endtask

    task automatic test_gaps();
        doReset();
        driveByte(8'h00); driveByte(8'h00); driveByte(8'h00); driveByte(8'h01);
        driveByte(8'h3C); idle(1);
        driveByte(8'h01); idle(1);
        driveByte(8'h00); idle(1);
        driveByte(8'h00); idle(3);
        checks++; if (wrQ.size() !== 1) begin errors++; $display("[TB] FAIL gaps.writes: got %0d expected 1", wrQ.size()); end
        if (wrQ.size() >= 1) begin
            checks++; if (wrQ[0].addr !== 12'd0 || wrQ[0].data !== 32'h3C01_0000) begin
                errors++; $display("[TB] FAIL gaps.w0: got %h/%h expected 000/3c010000", wrQ[0].addr, wrQ[0].data); end
        end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++; $display("[TB] FAIL gaps.final: got done=%b hold=%b expected 1/0", done, cpu_hold); end
    endtask

    task automatic test_reset_mid_load();
        byteQ_t s;
        logic [31:0] w;
        s = {8'h00, 8'h00, 8'h00, 8'h03};
        for (int j = 0; j < 6; j++) s.push_back(8'($urandom));
        doReset();
        applyStimulus(s, 0);
        checks++; if (wrQ.size() !== 1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset.before: got writes=%0d done=%b hold=%b expected 1/0/1", wrQ.size(), done, cpu_hold); end
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(3);
        checks++; if (wrQ.size() !== 1) begin errors++; $display("[TB] FAIL midreset.nowrite: got %0d expected 1", wrQ.size()); end
        checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== '0) begin
            errors++; $display("[TB] FAIL midreset.state: got ready=%b hold=%b done=%b count=%0d expected 1/1/0/0", in_ready, cpu_hold, done, word_count); end
        wrQ.delete();
        accFlag.delete();
        accEdge.delete();
        w = $urandom;
        s = {8'h00, 8'h00, 8'h00, 8'h01, w[31:24], w[23:16], w[15:8], w[7:0]};
        applyStimulus(s, 0);
        checks++; if (wrQ.size() !== 1) begin errors++; $display("[TB] FAIL midreset.rewrites: got %0d expected 1", wrQ.size()); end
        if (wrQ.size() >= 1) begin
            checks++; if (wrQ[0].addr !== 12'd0 || wrQ[0].data !== w) begin
                errors++; $display("[TB] FAIL midreset.w0: got %h/%h expected 000/%h", wrQ[0].addr, wrQ[0].data, w); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL midreset.done: got %b expected 1", done); end
    endtask

    task automatic test_full_depth();
        byteQ_t s;
        wordQ_t words;
        logic expDone, expErr;
        logic [ADDR_W:0] expCount;
        int expAcc, nAcc, bad;
        s = {8'h00, 8'h00, 8'h10, 8'h00};
        for (int j = 0; j < 4 * DEPTH + 3; j++) s.push_back(8'($urandom));
        modelLoad(s, words, expDone, expErr, expCount, expAcc);
        doReset();
        applyStimulus(s, 0);
        checks++; if (wrQ.size() !== DEPTH) begin errors++; $display("[TB] FAIL full.writes: got %0d expected %0d", wrQ.size(), DEPTH); end
        bad = 0;
        for (int i = 0; i < wrQ.size() && i < words.size(); i++)
            if (wrQ[i].addr !== ADDR_W'(i) || wrQ[i].data !== words[i] || wrQ[i].pc !== 32'h3000 + 32'(4 * i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL full.content: got %0d bad writes expected 0", bad); end
        if (wrQ.size() >= 1) begin
            checks++; if (wrQ[$].addr !== 12'hFFF || wrQ[$].pc !== 32'h0000_6FFC || wrQ[$].doneF !== 1'b1 || wrQ[$].holdF !== 1'b0) begin
                errors++; $display("[TB] FAIL full.last: got %h/%h done=%b hold=%b expected fff/00006ffc/1/0", wrQ[$].addr, wrQ[$].pc, wrQ[$].doneF, wrQ[$].holdF); end
        end
        nAcc = 0;
        foreach (accFlag[i]) if (accFlag[i] === 1'b1) nAcc++;
        checks++; if (nAcc !== expAcc || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL full.accept: got acc=%0d ready=%b expected %0d/0", nAcc, in_ready, expAcc); end
        checks++; if (done !== expDone || word_count !== expCount) begin
            errors++; $display("[TB] FAIL full.final: got done=%b count=%0d expected %b/%0d", done, word_count, expDone, expCount); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            byteQ_t s;
            wordQ_t words;
            logic [31:0] n;
            logic expDone, expErr;
            logic [ADDR_W:0] expCount;
            int expAcc, bad, badAcc, last;
            if (it % 4 == 3) n = $urandom_range(32'hFFFF_FFFF, DEPTH + 1);
            else             n = $urandom_range(5, 1);
            s = {n[31:24], n[23:16], n[15:8], n[7:0]};
            for (int j = 0; j < 4 * int'(n[3:0]); j++) s.push_back(8'($urandom));
            if (it % 3 == 1) begin
                int drop;
                drop = int'($urandom_range(3, 1));
                repeat (drop) void'(s.pop_back());
            end
            repeat ($urandom_range(2, 0)) s.push_back(8'($urandom));
            modelLoad(s, words, expDone, expErr, expCount, expAcc);
            doReset();
            applyStimulus(s, 30);
            checks++; if (wrQ.size() !== words.size()) begin
                errors++; $display("[TB] FAIL rand%0d.writes: got %0d expected %0d", it, wrQ.size(), words.size()); end
            bad = 0;
            last = words.size() - 1;
            for (int i = 0; i < wrQ.size() && i < words.size(); i++) begin
                if (wrQ[i].addr !== ADDR_W'(i) || wrQ[i].data !== words[i] || wrQ[i].pc !== 32'h3000 + 32'(4 * i)) bad++;
                if (wrQ[i].doneF !== (expDone && i == last) || wrQ[i].holdF !== !(expDone && i == last)) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rand%0d.content: got %0d bad writes expected 0", it, bad); end
            badAcc = 0;
            foreach (accFlag[i]) if (accFlag[i] !== (i < expAcc)) badAcc++;
            checks++; if (badAcc !== 0) begin errors++; $display("[TB] FAIL rand%0d.accept: got %0d wrong ready samples expected 0", it, badAcc); end
            checks++; if (done !== expDone || error !== expErr || cpu_hold !== !expDone || word_count !== expCount) begin
                errors++; $display("[TB] FAIL rand%0d.final: got done=%b err=%b hold=%b count=%0d expected %b/%b/%b/%0d",
                                   it, done, error, cpu_hold, word_count, expDone, expErr, !expDone, expCount); end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_byte = 8'h00;
        test_reset();
        test_two_words();
        test_zero_count();
        test_overflow();
        test_gaps();
        test_reset_mid_load();
        test_full_depth();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
